// File: rtl/venus_dma_desc_sched_if.sv
// Descriptor push / issue / completion bus of the Venus DMA descriptor scheduler.
//   slave  : the scheduler (accepts pushes from the CSR block, issues to the streamer,
//            receives completion status from the streamer)
//   master : the environment (CSR block plus streamer)
// Signals
//   push_valid_i/push_ch_i/push_src_i/push_dst_i/push_len_i -> descriptor push request
//   push_ready_o                                             <- push accepted when valid&ready
//   desc_valid_o/desc_src_o/desc_dst_o/desc_len_o/desc_ch_o  <- descriptor to streamer
//   desc_ready_i                                             -> streamer accepts descriptor
//   done_valid_i/err_valid_i/err_addr_i/err_src_i            -> in-flight completion status
interface venus_dma_desc_sched_if #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 32,
  parameter int BYTES_W = 32
);
  localparam int CH_W = $clog2(NUM_CH > 1 ? NUM_CH : 2);

  logic               push_valid_i;
  logic [CH_W-1:0]    push_ch_i;
  logic [ADDR_W-1:0]  push_src_i;
  logic [ADDR_W-1:0]  push_dst_i;
  logic [BYTES_W-1:0] push_len_i;
  logic               push_ready_o;

  logic               desc_valid_o;
  logic               desc_ready_i;
  logic [ADDR_W-1:0]  desc_src_o;
  logic [ADDR_W-1:0]  desc_dst_o;
  logic [BYTES_W-1:0] desc_len_o;
  logic [CH_W-1:0]    desc_ch_o;

  logic               done_valid_i;
  logic               err_valid_i;
  logic [ADDR_W-1:0]  err_addr_i;
  logic [1:0]         err_src_i;

  modport slave (
    input  push_valid_i, push_ch_i, push_src_i, push_dst_i, push_len_i,
    output push_ready_o,
    output desc_valid_o, desc_src_o, desc_dst_o, desc_len_o, desc_ch_o,
    input  desc_ready_i,
    input  done_valid_i, err_valid_i, err_addr_i, err_src_i
  );

  modport master (
    output push_valid_i, push_ch_i, push_src_i, push_dst_i, push_len_i,
    input  push_ready_o,
    input  desc_valid_o, desc_src_o, desc_dst_o, desc_len_o, desc_ch_o,
    output desc_ready_i,
    output done_valid_i, err_valid_i, err_addr_i, err_src_i
  );
endinterface

// File: rtl/venus_dma_desc_sched.sv
// Venus DMA multi-channel descriptor queue and scheduler.
// Per-channel DESC_DEPTH-entry descriptor FIFOs fed from the CSR block; enabled, non-empty,
// non-halted channels are round-robin arbitrated and one descriptor at a time is issued to
// the streamer. Tracks sticky per-channel done/error, a first-error record and an interrupt.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   bus             push / issue / completion bus (slave side)
//   ch_en_i         per-channel enable level
//   ch_abort_i      per-channel pulse: flush queue
//   status_clr_i    per-channel pulse: clear sticky done/error
//   err_clr_i       clear the first-error record
//   ch_active_o     queue non-empty or descriptor in flight
//   ch_done_o       sticky descriptor-completed flag
//   ch_error_o      sticky descriptor-failed flag (halts the channel)
//   ch_ocup_o       packed per-channel queue occupancy, DW+1 bits each
//   err_valid_o, err_ch_o, err_addr_o, err_src_o   first-error record
//   irq_o           registered OR of all done/error flags
module venus_dma_desc_sched #(
  parameter int NUM_CH     = 4,
  parameter int DESC_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int BYTES_W    = 32,
  localparam int CH_W      = $clog2(NUM_CH > 1 ? NUM_CH : 2),
  localparam int DW        = $clog2(DESC_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  venus_dma_desc_sched_if.slave    bus,
  input  logic [NUM_CH-1:0]        ch_en_i,
  input  logic [NUM_CH-1:0]        ch_abort_i,
  input  logic [NUM_CH-1:0]        status_clr_i,
  input  logic                     err_clr_i,
  output logic [NUM_CH-1:0]        ch_active_o,
  output logic [NUM_CH-1:0]        ch_done_o,
  output logic [NUM_CH-1:0]        ch_error_o,
  output logic [NUM_CH*(DW+1)-1:0] ch_ocup_o,
  output logic                     err_valid_o,
  output logic [CH_W-1:0]          err_ch_o,
  output logic [ADDR_W-1:0]        err_addr_o,
  output logic [1:0]               err_src_o,
  output logic                     irq_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [DW:0] DEPTH_C = (DW+1)'(DESC_DEPTH);

  // Descriptor storage is plain data: no reset needed.
  logic [ADDR_W-1:0]  r_src_mem [NUM_CH][DESC_DEPTH];
  logic [ADDR_W-1:0]  r_dst_mem [NUM_CH][DESC_DEPTH];
  logic [BYTES_W-1:0] r_len_mem [NUM_CH][DESC_DEPTH];
  logic [DW-1:0]      r_rd_ptr  [NUM_CH];
  logic [DW-1:0]      r_wr_ptr  [NUM_CH];
  logic [DW:0]        r_count   [NUM_CH];

  logic [1:0]         r_state;
  logic [CH_W-1:0]    r_rr_ptr;
  logic [ADDR_W-1:0]  r_desc_src, r_desc_dst;
  logic [BYTES_W-1:0] r_desc_len;
  logic [CH_W-1:0]    r_desc_ch;
  logic [NUM_CH-1:0]  r_done, r_error;
  logic               r_err_valid;
  logic [CH_W-1:0]    r_err_ch;
  logic [ADDR_W-1:0]  r_err_addr;
  logic [1:0]         r_err_src;
  logic               r_irq;

  logic                w_push_fire;
  logic [NUM_CH-1:0]   w_full, w_empty, w_elig, w_rot;
  logic [NUM_CH-1:0]   w_push_sel, w_pop_sel, w_done_set, w_err_set;
  logic                w_any_elig, w_pop;
  logic [CH_W-1:0]     w_off, w_grant, w_next_ptr;
  logic [CH_W:0]       w_sum;
  logic [BYTES_W-1:0]  w_head_len;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_full[c]  = (r_count[c] == DEPTH_C);
      w_empty[c] = (r_count[c] == '0);
    end
  end

  // Out-of-range channel numbers are never ready, so such pushes are silently refused.
  assign bus.push_ready_o = rst_n && (int'(bus.push_ch_i) < NUM_CH) && !w_full[bus.push_ch_i];
  assign w_push_fire      = bus.push_valid_i && bus.push_ready_o;
  assign w_elig           = ch_en_i & ~w_empty & ~r_error;

  // Rotate eligibility so bit 0 is the RR pointer; the lowest set bit is the grant offset.
  always_comb begin
    w_rot      = NUM_CH'({w_elig, w_elig} >> r_rr_ptr);
    w_any_elig = 1'b0;
    w_off      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_any_elig = 1'b1;
        w_off      = CH_W'(i);
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (int'(w_sum) >= NUM_CH) w_sum = w_sum - (CH_W+1)'(NUM_CH);
    w_grant = w_sum[CH_W-1:0];
    w_next_ptr = (int'(w_grant) + 1 >= NUM_CH) ? '0 : w_grant + 1'b1;
  end

  assign w_pop      = (r_state == S_IDLE) && w_any_elig;
  assign w_head_len = r_len_mem[w_grant][r_rd_ptr[w_grant]];

  // Zero-length descriptors complete at pop time without visiting the streamer.
  // Error beats done when the streamer reports both in the same cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_push_sel[c] = w_push_fire && (bus.push_ch_i == CH_W'(c)) && !ch_abort_i[c];
      w_pop_sel[c]  = w_pop && (w_grant == CH_W'(c));
      w_err_set[c]  = (r_state == S_BUSY) && bus.err_valid_i && (r_desc_ch == CH_W'(c));
      w_done_set[c] = ((r_state == S_BUSY) && bus.done_valid_i && !bus.err_valid_i &&
                       (r_desc_ch == CH_W'(c))) ||
                      (w_pop_sel[c] && (w_head_len == '0));
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push_sel[c]) begin
        r_src_mem[c][r_wr_ptr[c]] <= bus.push_src_i;
        r_dst_mem[c][r_wr_ptr[c]] <= bus.push_dst_i;
        r_len_mem[c][r_wr_ptr[c]] <= bus.push_len_i;
      end
    end
  end

  // An abort empties the queue; a descriptor popped in the same cycle still issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_rd_ptr[c] <= '0;
        r_wr_ptr[c] <= '0;
        r_count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_abort_i[c]) begin
          r_rd_ptr[c] <= '0;
          r_wr_ptr[c] <= '0;
          r_count[c]  <= '0;
        end else begin
          if (w_push_sel[c]) r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
          if (w_pop_sel[c])  r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
          r_count[c] <= r_count[c] + (DW+1)'(w_push_sel[c]) - (DW+1)'(w_pop_sel[c]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_desc_src <= '0;
      r_desc_dst <= '0;
      r_desc_len <= '0;
      r_desc_ch  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_rr_ptr <= w_next_ptr;
            if (w_head_len != '0) begin
              r_desc_src <= r_src_mem[w_grant][r_rd_ptr[w_grant]];
              r_desc_dst <= r_dst_mem[w_grant][r_rd_ptr[w_grant]];
              r_desc_len <= w_head_len;
              r_desc_ch  <= w_grant;
              r_state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: if (bus.desc_ready_i) r_state <= S_BUSY;
        S_BUSY:  if (bus.done_valid_i || bus.err_valid_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done      <= '0;
      r_error     <= '0;
      r_err_valid <= 1'b0;
      r_err_ch    <= '0;
      r_err_addr  <= '0;
      r_err_src   <= '0;
      r_irq       <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_done_set[c])        r_done[c] <= 1'b1;
        else if (status_clr_i[c]) r_done[c] <= 1'b0;
        if (w_err_set[c])         r_error[c] <= 1'b1;
        else if (status_clr_i[c]) r_error[c] <= 1'b0;
      end
      if ((|w_err_set) && (!r_err_valid || err_clr_i)) begin
        r_err_valid <= 1'b1;
        r_err_ch    <= r_desc_ch;
        r_err_addr  <= bus.err_addr_i;
        r_err_src   <= bus.err_src_i;
      end else if (err_clr_i) begin
        r_err_valid <= 1'b0;
      end
      r_irq <= |(r_done | r_error);
    end
  end

  always_comb begin
    ch_ocup_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_ocup_o[c*(DW+1) +: DW+1] = r_count[c];
      ch_active_o[c] = !w_empty[c] || ((r_state != S_IDLE) && (r_desc_ch == CH_W'(c)));
    end
  end

  assign bus.desc_valid_o = (r_state == S_ISSUE);
  assign bus.desc_src_o   = r_desc_src;
  assign bus.desc_dst_o   = r_desc_dst;
  assign bus.desc_len_o   = r_desc_len;
  assign bus.desc_ch_o    = r_desc_ch;
  assign ch_done_o        = r_done;
  assign ch_error_o       = r_error;
  assign err_valid_o      = r_err_valid;
  assign err_ch_o         = r_err_ch;
  assign err_addr_o       = r_err_addr;
  assign err_src_o        = r_err_src;
  assign irq_o            = r_irq;

endmodule

// File: tb/tb_venus_dma_desc_sched.sv
// Self-checking bench for venus_dma_desc_sched (NUM_CH=4, DESC_DEPTH=4).
// Accepted non-zero-length pushes go into a per-channel expected queue; every issued
// descriptor is popped from the queue of its channel and compared field by field.
`timescale 1ns/1ps
module tb_venus_dma_desc_sched;
  localparam int NUM_CH = 4, DESC_DEPTH = 4, ADDR_W = 32, BYTES_W = 32;
  localparam int CH_W = 2, DW = 2;

  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic [ADDR_W-1:0]  src;
    logic [ADDR_W-1:0]  dst;
    logic [BYTES_W-1:0] len;
  } desc_t;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH-1:0]        ch_en_i, ch_abort_i, status_clr_i;
  logic                     err_clr_i;
  logic [NUM_CH-1:0]        ch_active_o, ch_done_o, ch_error_o;
  logic [NUM_CH*(DW+1)-1:0] ch_ocup_o;
  logic                     err_valid_o;
  logic [CH_W-1:0]          err_ch_o;
  logic [ADDR_W-1:0]        err_addr_o;
  logic [1:0]               err_src_o;
  logic                     irq_o;

  venus_dma_desc_sched_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BYTES_W(BYTES_W)) bus ();

  venus_dma_desc_sched #(.NUM_CH(NUM_CH), .DESC_DEPTH(DESC_DEPTH), .ADDR_W(ADDR_W),
                         .BYTES_W(BYTES_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ch_en_i(ch_en_i), .ch_abort_i(ch_abort_i), .status_clr_i(status_clr_i),
    .err_clr_i(err_clr_i), .ch_active_o(ch_active_o), .ch_done_o(ch_done_o),
    .ch_error_o(ch_error_o), .ch_ocup_o(ch_ocup_o), .err_valid_o(err_valid_o),
    .err_ch_o(err_ch_o), .err_addr_o(err_addr_o), .err_src_o(err_src_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  desc_t exp_q [NUM_CH][$];

  task automatic idle_inputs();
    bus.push_valid_i = 1'b0; bus.push_ch_i = '0; bus.push_src_i = '0;
    bus.push_dst_i = '0; bus.push_len_i = '0; bus.desc_ready_i = 1'b0;
    bus.done_valid_i = 1'b0; bus.err_valid_i = 1'b0; bus.err_addr_i = '0; bus.err_src_i = '0;
    ch_en_i = '0; ch_abort_i = '0; status_clr_i = '0; err_clr_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One-cycle push, started and finished at a negedge.
  task automatic push(input int ch, input logic [31:0] src, input logic [31:0] dst,
                      input logic [31:0] len, input bit exp_rdy);
    desc_t d;
    d = {CH_W'(ch), src, dst, len};
    bus.push_valid_i = 1'b1; bus.push_ch_i = CH_W'(ch);
    bus.push_src_i = src; bus.push_dst_i = dst; bus.push_len_i = len;
    #1;
    n_vec++;
    if (bus.push_ready_o !== exp_rdy) begin
      n_err++;
      $display("FAIL push_ready ch%0d: got %b want %b", ch, bus.push_ready_o, exp_rdy);
    end
    if (exp_rdy && len != 0) exp_q[ch].push_back(d);
    @(negedge clk);
    bus.push_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.desc_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Streamer: accept the issued descriptor, then report completion one cycle in BUSY.
  task automatic stream_end(input bit d, input bit e, input logic [31:0] addr,
                            input logic [1:0] src);
    bus.desc_ready_i = 1'b1;
    @(negedge clk);
    bus.desc_ready_i = 1'b0;
    bus.done_valid_i = d; bus.err_valid_i = e; bus.err_addr_i = addr; bus.err_src_i = src;
    @(negedge clk);
    bus.done_valid_i = 1'b0; bus.err_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (bus.push_ready_o !== 1'b0) begin
      n_err++; $display("FAIL reset_push_ready: got %b want 0", bus.push_ready_o);
    end
    n_vec++;
    if ({bus.desc_valid_o, ch_active_o, ch_done_o, ch_error_o, ch_ocup_o, err_valid_o, irq_o}
        !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b act=%b done=%b err=%b ocup=%h ev=%b irq=%b want 0",
               bus.desc_valid_o, ch_active_o, ch_done_o, ch_error_o, ch_ocup_o, err_valid_o, irq_o);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (bus.push_ready_o !== 1'b1) begin
      n_err++; $display("FAIL post_reset_push_ready: got %b want 1", bus.push_ready_o);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    desc_t got, exp;
    do_reset();
    ch_en_i = 4'b0001;
    push(0, 32'h1000, 32'h2000, 32'h40, 1'b1);
    n_vec++;
    if (bus.desc_valid_o !== 1'b0) begin
      n_err++; $display("FAIL latency_t1: desc_valid got %b want 0", bus.desc_valid_o);
    end
    @(negedge clk);
    n_vec++;
    if (bus.desc_valid_o !== 1'b1) begin
      n_err++; $display("FAIL latency_t2: desc_valid got %b want 1", bus.desc_valid_o);
    end
    got = {bus.desc_ch_o, bus.desc_src_o, bus.desc_dst_o, bus.desc_len_o};
    exp = exp_q[0].pop_front();
    n_vec++;
    if (got !== exp) begin
      n_err++; $display("FAIL single_issue: got %h want %h", got, exp);
    end
    n_vec++;
    if (ch_active_o !== 4'b0001) begin
      n_err++; $display("FAIL single_active: got %b want 0001", ch_active_o);
    end
    stream_end(1'b1, 1'b0, 32'h0, 2'd0);
    n_vec++;
    if ({ch_done_o, ch_active_o, irq_o} !== {4'b0001, 4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL single_done: done=%b act=%b irq=%b want 0001 0000 0", ch_done_o, ch_active_o, irq_o);
    end
    @(negedge clk);
    n_vec++;
    if (irq_o !== 1'b1) begin
      n_err++; $display("FAIL single_irq: got %b want 1", irq_o);
    end
  endtask

  task automatic test_round_robin();
    desc_t got, exp;
    bit    ok;
    int    cnt [NUM_CH];
    do_reset();
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < NUM_CH; c++)
        push(c, 32'h1000_0000 + 32'(c) * 32'h1000 + 32'(d) * 32'h10,
             32'h2000_0000 + 32'(c) * 32'h1000 + 32'(d) * 32'h10,
             32'h100 + 32'(c) * 32'h10 + 32'(d), 1'b1);
    for (int c = 0; c < NUM_CH; c++) cnt[c] = 4;
    n_vec++;
    if (ch_ocup_o !== 12'b100_100_100_100) begin
      n_err++; $display("FAIL rr_ocup_full: got %b want 100100100100", ch_ocup_o);
    end
    ch_en_i = 4'hF;
    for (int k = 0; k < 16; k++) begin
      wait_valid(ok);
      n_vec++;
      if (!ok) begin
        n_err++; $display("FAIL rr_timeout: issue %0d got none want ch%0d", k, k % NUM_CH);
        break;
      end
      got = {bus.desc_ch_o, bus.desc_src_o, bus.desc_dst_o, bus.desc_len_o};
      n_vec++;
      if (got.ch !== CH_W'(k % NUM_CH)) begin
        n_err++; $display("FAIL rr_order: issue %0d got ch%0d want ch%0d", k, got.ch, k % NUM_CH);
      end
      n_vec++;
      if (exp_q[got.ch].size() == 0) begin
        n_err++; $display("FAIL rr_issue: got %h want nothing", got);
      end else begin
        exp = exp_q[got.ch].pop_front();
        cnt[got.ch]--;
        if (got !== exp) begin
          n_err++; $display("FAIL rr_issue: got %h want %h", got, exp);
        end
        n_vec++;
        if (ch_ocup_o[got.ch*3 +: 3] !== 3'(cnt[got.ch])) begin
          n_err++;
          $display("FAIL rr_ocup ch%0d: got %0d want %0d", got.ch, ch_ocup_o[got.ch*3 +: 3], cnt[got.ch]);
        end
      end
      stream_end(1'b1, 1'b0, 32'h0, 2'd0);
    end
    n_vec++;
    if ({ch_ocup_o, ch_done_o} !== {12'b0, 4'hF}) begin
      n_err++; $display("FAIL rr_final: ocup=%h done=%b want 000 1111", ch_ocup_o, ch_done_o);
    end
    n_vec++;
    if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() != 0) begin
      n_err++; $display("FAIL rr_drain: leftover expected descriptors, want 0");
    end
  endtask

  task automatic test_full_abort();
    do_reset();
    for (int i = 0; i < 5; i++)
      push(1, 32'h5000 + 32'(i), 32'h6000, 32'h8, i < 4);
    n_vec++;
    if ({ch_ocup_o[3 +: 3], ch_active_o} !== {3'd4, 4'b0010}) begin
      n_err++; $display("FAIL full_ocup: ocup1=%0d act=%b want 4 0010", ch_ocup_o[3 +: 3], ch_active_o);
    end
    ch_abort_i = 4'b0010;
    @(negedge clk);
    ch_abort_i = '0;
    exp_q[1].delete();
    n_vec++;
    if ({ch_ocup_o, ch_active_o} !== '0) begin
      n_err++; $display("FAIL abort: ocup=%h act=%b want 0 0", ch_ocup_o, ch_active_o);
    end
    bus.push_ch_i = 2'd1;
    #1;
    n_vec++;
    if (bus.push_ready_o !== 1'b1) begin
      n_err++; $display("FAIL abort_ready: got %b want 1", bus.push_ready_o);
    end
    @(negedge clk);
  endtask

  task automatic test_error();
    desc_t got, exp;
    bit    ok, saw;
    do_reset();
    ch_en_i = 4'hF;
    push(2, 32'hA000, 32'hA100, 32'h80, 1'b1);
    push(2, 32'hB000, 32'hB100, 32'h90, 1'b1);
    push(3, 32'hC000, 32'hC100, 32'hA0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok);
      got = {bus.desc_ch_o, bus.desc_src_o, bus.desc_dst_o, bus.desc_len_o};
      n_vec++;
      if (!ok || got.ch !== CH_W'(2 + k) || exp_q[2 + k].size() == 0) begin
        n_err++; $display("FAIL err_issue%0d: valid=%b got %h want ch%0d", k, ok, got, 2 + k);
      end else begin
        exp = exp_q[2 + k].pop_front();
        if (got !== exp) begin
          n_err++; $display("FAIL err_issue%0d: got %h want %h", k, got, exp);
        end
      end
      stream_end(1'b0, 1'b1, (k == 0) ? 32'h3000 : 32'h4000, 2'(k));
    end
    saw = 1'b0;
    repeat (3) begin
      saw |= bus.desc_valid_o;
      @(negedge clk);
    end
    n_vec++;
    if (saw !== 1'b0) begin
      n_err++; $display("FAIL err_halt: desc_valid seen %b want 0", saw);
    end
    n_vec++;
    if ({err_valid_o, err_ch_o, err_addr_o, err_src_o} !== {1'b1, 2'd2, 32'h3000, 2'd0}) begin
      n_err++;
      $display("FAIL err_record: v=%b ch=%0d addr=%h src=%0d want 1 2 3000 0",
               err_valid_o, err_ch_o, err_addr_o, err_src_o);
    end
    n_vec++;
    if ({ch_error_o, ch_ocup_o[6 +: 3]} !== {4'b1100, 3'd1}) begin
      n_err++; $display("FAIL err_flags: err=%b ocup2=%0d want 1100 1", ch_error_o, ch_ocup_o[6 +: 3]);
    end
    status_clr_i = 4'b0100;
    @(negedge clk);
    status_clr_i = '0;
    wait_valid(ok);
    got = {bus.desc_ch_o, bus.desc_src_o, bus.desc_dst_o, bus.desc_len_o};
    n_vec++;
    if (!ok || got.ch !== 2'd2 || exp_q[2].size() == 0) begin
      n_err++; $display("FAIL err_resume: valid=%b got %h want ch2", ok, got);
    end else begin
      exp = exp_q[2].pop_front();
      if (got !== exp) begin
        n_err++; $display("FAIL err_resume: got %h want %h", got, exp);
      end
    end
    stream_end(1'b1, 1'b0, 32'h0, 2'd0);
    n_vec++;
    if ({ch_error_o, ch_done_o[2]} !== {4'b1000, 1'b1}) begin
      n_err++; $display("FAIL err_after_resume: err=%b done2=%b want 1000 1", ch_error_o, ch_done_o[2]);
    end
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    n_vec++;
    if (err_valid_o !== 1'b0) begin
      n_err++; $display("FAIL err_clr: got %b want 0", err_valid_o);
    end
  endtask

  task automatic test_done_err_and_zero_len();
    desc_t got, exp;
    bit    ok, saw;
    do_reset();
    ch_en_i = 4'b0001;
    push(0, 32'hD000, 32'hD100, 32'h20, 1'b1);
    wait_valid(ok);
    got = {bus.desc_ch_o, bus.desc_src_o, bus.desc_dst_o, bus.desc_len_o};
    n_vec++;
    if (!ok || exp_q[0].size() == 0) begin
      n_err++; $display("FAIL both_issue: valid=%b got %h want ch0", ok, got);
    end else begin
      exp = exp_q[0].pop_front();
      if (got !== exp) begin
        n_err++; $display("FAIL both_issue: got %h want %h", got, exp);
      end
    end
    stream_end(1'b1, 1'b1, 32'h5000, 2'd2);
    n_vec++;
    if ({ch_done_o[0], ch_error_o[0], err_ch_o, err_src_o} !== {1'b0, 1'b1, 2'd0, 2'd2}) begin
      n_err++;
      $display("FAIL both_status: done0=%b err0=%b ch=%0d src=%0d want 0 1 0 2",
               ch_done_o[0], ch_error_o[0], err_ch_o, err_src_o);
    end
    status_clr_i = 4'b0001;
    @(negedge clk);
    status_clr_i = '0;
    push(0, 32'hE000, 32'hE100, 32'h0, 1'b1);
    saw = 1'b0;
    repeat (6) begin
      saw |= bus.desc_valid_o;
      @(negedge clk);
    end
    n_vec++;
    if ({saw, ch_done_o[0], ch_error_o[0], ch_ocup_o} !== {1'b0, 1'b1, 1'b0, 12'b0}) begin
      n_err++;
      $display("FAIL zero_len: seen=%b done0=%b err0=%b ocup=%h want 0 1 0 000",
               saw, ch_done_o[0], ch_error_o[0], ch_ocup_o);
    end
  endtask

  task automatic test_stall_and_reset();
    desc_t got, exp;
    bit    ok;
    do_reset();
    ch_en_i = 4'hF;
    push(1, 32'hF000, 32'hF100, 32'h44, 1'b1);
    wait_valid(ok);
    exp = (exp_q[1].size() != 0) ? exp_q[1].pop_front() : '0;
    for (int i = 0; i < 10; i++) begin
      got = {bus.desc_ch_o, bus.desc_src_o, bus.desc_dst_o, bus.desc_len_o};
      n_vec++;
      if ({bus.desc_valid_o, got} !== {1'b1, exp}) begin
        n_err++; $display("FAIL stall cycle %0d: valid=%b got %h want 1 %h", i, bus.desc_valid_o, got, exp);
      end
      @(negedge clk);
    end
    push(0, 32'h7000, 32'h7100, 32'h10, 1'b1);
    bus.desc_ready_i = 1'b1;
    @(negedge clk);
    bus.desc_ready_i = 1'b0;
    n_vec++;
    if ({bus.desc_valid_o, ch_active_o} !== {1'b0, 4'b0011}) begin
      n_err++; $display("FAIL busy_state: valid=%b act=%b want 0 0011", bus.desc_valid_o, ch_active_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.push_ready_o, bus.desc_valid_o, bus.desc_src_o, bus.desc_len_o, ch_active_o,
         ch_done_o, ch_error_o, ch_ocup_o, err_valid_o, irq_o} !== '0) begin
      n_err++;
      $display("FAIL async_reset: rdy=%b valid=%b src=%h act=%b done=%b ocup=%h irq=%b want 0",
               bus.push_ready_o, bus.desc_valid_o, bus.desc_src_o, ch_active_o, ch_done_o,
               ch_ocup_o, irq_o);
    end
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.desc_valid_o, ch_active_o, ch_ocup_o} !== '0) begin
      n_err++; $display("FAIL after_reset: valid=%b act=%b ocup=%h want 0", bus.desc_valid_o, ch_active_o, ch_ocup_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_abort();
    test_error();
    test_done_err_and_zero_len();
    test_stall_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
